// File: rtl/eth_tx_fcs.sv
// Ethernet TX frame finisher: pass-through payload, optional zero padding, CRC-32 FCS, inter-frame gap.
// Define ETH_TX_PAD_EN to build the padding path for frames shorter than MIN_FRAME.
`timescale 1ns/1ps
module eth_tx_fcs #(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_in_data,
    input  logic       tx_in_valid,
    input  logic       tx_in_last,
    input  logic       tx_in_user,
    output logic       tx_in_ready,
    output logic [7:0] mac_tx_data,
    output logic       mac_tx_valid,
    output logic       mac_tx_last,
    output logic       mac_tx_user,
    input  logic       mac_tx_ready
);

    localparam logic [6:0]  MIN_CNT  = 7'(MIN_FRAME);
    localparam logic [15:0] IFG_END  = 16'(IFG_CYCLES - 1);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, IFG} state_t;

    state_t      state, state_d;
    logic [31:0] crc, crc_d;
    logic [6:0]  byte_cnt, cnt_d;
    logic        err, err_d;
    logic [1:0]  fcs_idx, idx_d;
    logic [15:0] ifg_cnt, ifg_d;
    logic [31:0] fcs;
    logic        pad_needed;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [6:0] cnt_sat(input logic [6:0] c);
        return (c < MIN_CNT) ? c + 7'd1 : c;
    endfunction

    assign fcs = ~crc;

`ifdef ETH_TX_PAD_EN
    assign pad_needed = ({1'b0, byte_cnt} + 8'd1) < {1'b0, MIN_CNT};
`else
    assign pad_needed = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        crc_d        = crc;
        cnt_d        = byte_cnt;
        err_d        = err;
        idx_d        = fcs_idx;
        ifg_d        = ifg_cnt;
        tx_in_ready  = 1'b0;
        mac_tx_data  = 8'h00;
        mac_tx_valid = 1'b0;
        mac_tx_last  = 1'b0;
        mac_tx_user  = 1'b0;
        case (state)
            IDLE, DATA: begin
                tx_in_ready  = mac_tx_ready;
                mac_tx_valid = tx_in_valid;
                mac_tx_data  = tx_in_data;
                if (tx_in_valid && mac_tx_ready) begin
                    crc_d = crc_next(crc, tx_in_data);
                    cnt_d = cnt_sat(byte_cnt);
                    err_d = err | tx_in_user;
                    if (tx_in_last)
                        state_d = pad_needed ? PAD : FCS;
                    else
                        state_d = DATA;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                mac_tx_valid = 1'b1;
                if (mac_tx_ready) begin
                    crc_d = crc_next(crc, 8'h00);
                    cnt_d = cnt_sat(byte_cnt);
                    if (cnt_sat(byte_cnt) == MIN_CNT)
                        state_d = FCS;
                end
            end
`endif
            FCS: begin
                mac_tx_valid = 1'b1;
                case (fcs_idx)
                    2'd0:    mac_tx_data = fcs[7:0];
                    2'd1:    mac_tx_data = fcs[15:8];
                    2'd2:    mac_tx_data = fcs[23:16];
                    default: mac_tx_data = fcs[31:24];
                endcase
                mac_tx_last = (fcs_idx == 2'd3);
                mac_tx_user = err && (fcs_idx == 2'd3);
                if (mac_tx_ready) begin
                    idx_d = fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        state_d = IFG;
                        ifg_d   = 16'd0;
                    end
                end
            end
            IFG: begin
                // Gap is timed in cycles; the MAC's ready is irrelevant here.
                if (ifg_cnt == IFG_END) begin
                    state_d = IDLE;
                    crc_d   = CRC_INIT;
                    cnt_d   = 7'd0;
                    err_d   = 1'b0;
                end else begin
                    ifg_d = ifg_cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sys_rst) begin
            tx_in_ready  = 1'b0;
            mac_tx_valid = 1'b0;
            mac_tx_last  = 1'b0;
            mac_tx_user  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            crc      <= CRC_INIT;
            byte_cnt <= 7'd0;
            err      <= 1'b0;
            fcs_idx  <= 2'd0;
            ifg_cnt  <= 16'd0;
        end else begin
            state    <= state_d;
            crc      <= crc_d;
            byte_cnt <= cnt_d;
            err      <= err_d;
            fcs_idx  <= idx_d;
            ifg_cnt  <= ifg_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Directed self-checking bench for eth_tx_fcs; follows ETH_TX_PAD_EN when it is defined.
`timescale 1ns/1ps
module tb_eth_tx_fcs;

    localparam int MIN_FRAME  = 60;
    localparam int IFG_CYCLES = 12;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] tx_in_data = 8'h00;
    logic       tx_in_valid = 1'b0;
    logic       tx_in_last = 1'b0;
    logic       tx_in_user = 1'b0;
    logic       tx_in_ready;
    logic [7:0] mac_tx_data;
    logic       mac_tx_valid;
    logic       mac_tx_last;
    logic       mac_tx_user;
    logic       mac_tx_ready = 1'b1;

    eth_tx_fcs #(.MIN_FRAME(MIN_FRAME), .IFG_CYCLES(IFG_CYCLES)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tx_in_data(tx_in_data), .tx_in_valid(tx_in_valid), .tx_in_last(tx_in_last),
        .tx_in_user(tx_in_user), .tx_in_ready(tx_in_ready),
        .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid), .mac_tx_last(mac_tx_last),
        .mac_tx_user(mac_tx_user), .mac_tx_ready(mac_tx_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc_no = 0;
    always @(posedge sys_clk) cyc_no <= cyc_no + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] frame [0:255];
    logic [7:0] out_q[$];
    logic       out_last_q[$];
    logic       out_user_q[$];
    logic [7:0] exp_q[$];
    int         last_hs_cyc, first_acc_cyc, ready_low_before, stall_viol;
    bit         timed_out;

    // Bit-serial reference CRC over exp_q, returned already complemented.
    function automatic logic [31:0] model_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (exp_q[k])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ exp_q[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        return ~c;
    endfunction

    task automatic build_exp(input int len);
        logic [31:0] f;
        exp_q.delete();
        for (int k = 0; k < len; k++) exp_q.push_back(frame[k]);
`ifdef ETH_TX_PAD_EN
        while (exp_q.size() < MIN_FRAME) exp_q.push_back(8'h00);
`endif
        f = model_fcs();
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
    endtask

    function automatic int first_diff();
        for (int k = 0; k < out_q.size() && k < exp_q.size(); k++)
            if (out_q[k] !== exp_q[k]) return k;
        if (out_q.size() != exp_q.size()) return (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        return -1;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (out_last_q[k]) if (out_last_q[k]) n++;
        return n;
    endfunction

    function automatic int count_user();
        int n = 0;
        foreach (out_user_q[k]) if (out_user_q[k]) n++;
        return n;
    endfunction

    task automatic fill_frame(input int len, input int seed);
        for (int k = 0; k < len; k++) frame[k] = 8'((k * 37 + seed * 11 + 5) & 255);
    endtask

    // Drives one frame and captures every output handshake until mac_tx_last.
    task automatic send_frame(input int len, input int err_idx, input bit toggle, input bit gaps);
        int         i = 0;
        int         cyc = 0;
        bit         done = 0;
        bit         seen_acc = 0;
        bit         prev_stall = 0;
        logic [7:0] held_data = 8'h00;
        logic       held_last = 1'b0;
        out_q.delete(); out_last_q.delete(); out_user_q.delete();
        stall_viol = 0; ready_low_before = 0; first_acc_cyc = -1;
        while (!done && cyc < 3000) begin
            tx_in_valid  = (i < len) && !(gaps && (cyc % 3 == 2));
            tx_in_data   = (i < len) ? frame[i] : 8'h00;
            tx_in_last   = (i == len - 1);
            tx_in_user   = (i == err_idx);
            mac_tx_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            @(negedge sys_clk);
            if (prev_stall && (!mac_tx_valid || mac_tx_data !== held_data || mac_tx_last !== held_last))
                stall_viol++;
            prev_stall = mac_tx_valid && !mac_tx_ready;
            held_data  = mac_tx_data;
            held_last  = mac_tx_last;
            if (tx_in_valid && tx_in_ready) begin
                if (!seen_acc) begin
                    seen_acc = 1;
                    first_acc_cyc = cyc_no;
                end
                i++;
            end else if (!seen_acc && !tx_in_ready) begin
                ready_low_before++;
            end
            if (mac_tx_valid && mac_tx_ready) begin
                out_q.push_back(mac_tx_data);
                out_last_q.push_back(mac_tx_last);
                out_user_q.push_back(mac_tx_user);
                if (mac_tx_last) begin
                    done = 1;
                    last_hs_cyc = cyc_no;
                end
            end
            @(posedge sys_clk); #1;
            cyc++;
        end
        tx_in_valid = 0; tx_in_last = 0; tx_in_user = 0; mac_tx_ready = 1;
        timed_out = !done;
    endtask

    task automatic test_reset();
        sys_rst = 1; tx_in_valid = 1; tx_in_data = 8'hAA; tx_in_last = 1; tx_in_user = 1; mac_tx_ready = 1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        vectors++;
        if (tx_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", tx_in_ready); end
        vectors++;
        if (mac_tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", mac_tx_valid); end
        vectors++;
        if (mac_tx_last !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %b want 0", mac_tx_last); end
        vectors++;
        if (mac_tx_user !== 1'b0) begin miscompares++; $display("FAIL rst_user: got %b want 0", mac_tx_user); end
        @(posedge sys_clk); #1;
        sys_rst = 0; tx_in_valid = 0; tx_in_last = 0; tx_in_user = 0;
        @(negedge sys_clk);
        vectors++;
        if ({tx_in_ready, mac_tx_valid} !== 2'b10)
            begin miscompares++; $display("FAIL idle_after_rst: got ready/valid %b want 10", {tx_in_ready, mac_tx_valid}); end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_check_value();
        logic [31:0] got_fcs;
        int          d;
        for (int k = 0; k < 9; k++) frame[k] = 8'(8'h31 + k);
        build_exp(9);
        send_frame(9, -1, 0, 0);
        vectors++;
`ifdef ETH_TX_PAD_EN
        if (timed_out || out_q.size() != 64)
            begin miscompares++; $display("FAIL chk_len: got %0d bytes want 64 (timeout=%0d)", out_q.size(), timed_out); end
`else
        if (timed_out || out_q.size() != 13)
            begin miscompares++; $display("FAIL chk_len: got %0d bytes want 13 (timeout=%0d)", out_q.size(), timed_out); end
        got_fcs = {out_q[12], out_q[11], out_q[10], out_q[9]};
        vectors++;
        if (got_fcs !== 32'hCBF4_3926)
            begin miscompares++; $display("FAIL chk_fcs: got %h want cbf43926", got_fcs); end
`endif
        d = first_diff();
        vectors++;
        if (d != -1)
            begin miscompares++; $display("FAIL chk_bytes: first diff at %0d got %h want %h", d, out_q[d], exp_q[d]); end
        vectors++;
        if (count_last() != 1 || out_last_q[out_q.size()-1] !== 1'b1)
            begin miscompares++; $display("FAIL chk_last: got %0d last flags want 1 on final byte", count_last()); end
        vectors++;
        if (count_user() != 0)
            begin miscompares++; $display("FAIL chk_user: got %0d user flags want 0", count_user()); end
    endtask

    task automatic test_backpressure();
        int d;
        fill_frame(100, 3);
        build_exp(100);
        send_frame(100, -1, 1, 0);
        vectors++;
        if (timed_out || out_q.size() != 104)
            begin miscompares++; $display("FAIL bp_len: got %0d bytes want 104 (timeout=%0d)", out_q.size(), timed_out); end
        d = first_diff();
        vectors++;
        if (d != -1)
            begin miscompares++; $display("FAIL bp_bytes: first diff at %0d got %h want %h", d, out_q[d], exp_q[d]); end
        vectors++;
        if (stall_viol != 0)
            begin miscompares++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol); end
        vectors++;
        if (count_last() != 1 || out_last_q[out_q.size()-1] !== 1'b1)
            begin miscompares++; $display("FAIL bp_last: got %0d last flags want 1", count_last()); end
    endtask

    task automatic test_error();
        int d;
        fill_frame(70, 7);
        build_exp(70);
        send_frame(70, 4, 0, 1);
        d = first_diff();
        vectors++;
        if (timed_out || d != -1)
            begin miscompares++; $display("FAIL err_bytes: diff at %0d size %0d want %0d", d, out_q.size(), exp_q.size()); end
        vectors++;
        if (count_user() != 1 || out_user_q[out_q.size()-1] !== 1'b1 || out_last_q[out_q.size()-1] !== 1'b1)
            begin miscompares++; $display("FAIL err_user: got %0d user flags want 1 on last byte", count_user()); end
        fill_frame(61, 9);
        build_exp(61);
        send_frame(61, -1, 0, 0);
        d = first_diff();
        vectors++;
        if (timed_out || d != -1)
            begin miscompares++; $display("FAIL clean_bytes: diff at %0d size %0d want %0d", d, out_q.size(), exp_q.size()); end
        vectors++;
        if (count_user() != 0)
            begin miscompares++; $display("FAIL clean_user: got %0d user flags want 0", count_user()); end
    endtask

    task automatic test_back_to_back();
        int a_last, d;
        fill_frame(64, 2);
        build_exp(64);
        send_frame(64, -1, 0, 0);
        a_last = last_hs_cyc;
        d = first_diff();
        vectors++;
        if (timed_out || d != -1)
            begin miscompares++; $display("FAIL b2b_a_bytes: diff at %0d size %0d", d, out_q.size()); end
        fill_frame(65, 4);
        build_exp(65);
        send_frame(65, -1, 0, 0);
        vectors++;
        if (ready_low_before != IFG_CYCLES)
            begin miscompares++; $display("FAIL b2b_gap: got %0d ready-low cycles want %0d", ready_low_before, IFG_CYCLES); end
        vectors++;
        if (first_acc_cyc - a_last != IFG_CYCLES + 1)
            begin miscompares++; $display("FAIL b2b_accept: got cycle %0d want %0d", first_acc_cyc - a_last, IFG_CYCLES + 1); end
        d = first_diff();
        vectors++;
        if (timed_out || d != -1)
            begin miscompares++; $display("FAIL b2b_b_bytes: diff at %0d size %0d", d, out_q.size()); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int guard = 0;
        int d;
        fill_frame(80, 5);
        mac_tx_ready = 1;
        while (k < 19 && guard < 500) begin
            tx_in_valid = 1; tx_in_data = frame[k]; tx_in_last = 0; tx_in_user = 0;
            @(negedge sys_clk);
            if (tx_in_ready) k++;
            @(posedge sys_clk); #1;
            guard++;
        end
        vectors++;
        if (k != 19)
            begin miscompares++; $display("FAIL mid_prefix: got %0d bytes accepted want 19", k); end
        tx_in_valid = 1; tx_in_data = frame[19]; sys_rst = 1;
        @(negedge sys_clk);
        vectors++;
        if ({tx_in_ready, mac_tx_valid} !== 2'b00)
            begin miscompares++; $display("FAIL mid_rst: got ready/valid %b want 00", {tx_in_ready, mac_tx_valid}); end
        @(posedge sys_clk); #1;
        sys_rst = 0; tx_in_valid = 0;
        @(negedge sys_clk);
        vectors++;
        if ({mac_tx_valid, mac_tx_last, mac_tx_user} !== 3'b000)
            begin miscompares++; $display("FAIL mid_after: got valid/last/user %b want 000", {mac_tx_valid, mac_tx_last, mac_tx_user}); end
        @(posedge sys_clk); #1;
        fill_frame(64, 6);
        build_exp(64);
        send_frame(64, -1, 0, 0);
        d = first_diff();
        vectors++;
        if (timed_out || out_q.size() != 68 || d != -1)
            begin miscompares++; $display("FAIL mid_next_fcs: diff at %0d size %0d want 68", d, out_q.size()); end
    endtask

    initial begin
        test_reset();
        test_check_value();
        test_backpressure();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
